// File: rtl/wddl_arith_pkg.sv
// Shared definitions for the WDDL (dual-rail) modular arithmetic datapath:
// ML-KEM modulus, datapath width, sequencer states and the dual-rail pair type.
package wddl_arith_pkg;

    localparam int MLKEM_Q = 3329;
    localparam int WDDL_W  = 12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE1     = 3'd1,
        EVAL_SUB = 3'd2,
        PRE2     = 3'd3,
        EVAL_COR = 3'd4,
        DONE     = 3'd5
    } wddl_state_e;

    // One dual-rail bit: t carries the value, f its complement; 0/0 is precharge.
    typedef struct packed {
        logic t;
        logic f;
    } dr_t;

endpackage

// File: rtl/wddl_mod_sub_seq_sub.sv
// Combinational WDDL ripple adder of N dual-rail bits. Built only from
// positive (AND/OR) gates on the rails so an all-zero input wave yields an
// all-zero output wave. Subtraction is obtained at the instance by swapping
// the b rails and driving carry-in (1,0).
module subtractor_13_bit_WDDL #(
    parameter int N = 13
) (
    input  logic [N-1:0] a_t,
    input  logic [N-1:0] a_f,
    input  logic [N-1:0] b_t,
    input  logic [N-1:0] b_f,
    input  logic         cin_t,
    input  logic         cin_f,
    output logic [N-1:0] s_t,
    output logic [N-1:0] s_f
);

    logic [N-1:0] c_t;
    logic [N-1:0] c_f;

    assign c_t[0] = cin_t;
    assign c_f[0] = cin_f;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            logic p_t;
            logic p_f;
            // Dual-rail XOR of the operand bits
            assign p_t = (a_t[i] & b_f[i]) | (a_f[i] & b_t[i]);
            assign p_f = (a_t[i] & b_t[i]) | (a_f[i] & b_f[i]);
            // Dual-rail XOR with the incoming carry
            assign s_t[i] = (p_t & c_f[i]) | (p_f & c_t[i]);
            assign s_f[i] = (p_t & c_t[i]) | (p_f & c_f[i]);
            // Majority on each rail; the carry out of the top bit is not needed
            if (i < N - 1) begin : g_carry
                assign c_t[i+1] = (a_t[i] & b_t[i]) | (a_t[i] & c_t[i]) | (b_t[i] & c_t[i]);
                assign c_f[i+1] = (a_f[i] & b_f[i]) | (a_f[i] & c_f[i]) | (b_f[i] & c_f[i]);
            end
        end
    endgenerate

endmodule

// File: rtl/wddl_mod_sub_seq.sv
// Sequential WDDL modular subtractor: res = (a - b) mod Q on complementary
// rails, with precharge cycles ahead of both evaluations.
// Optional build macro WDDL_RAIL_CHECK_EN enables the sticky rail_err
// complementarity monitor; without it rail_err is tied low.
module wddl_mod_sub_seq
    import wddl_arith_pkg::*;
#(
    parameter int Q = MLKEM_Q,
    parameter int W = WDDL_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic [W-1:0] res_n,
    output logic         rail_err
);

    localparam logic [W-1:0] Q_BITS = W'(Q);

    wddl_state_e  state;
    logic [W-1:0] lat_a, lat_b;
    logic [W-1:0] op_at, op_af, op_bt, op_bf;
    logic [W-1:0] diff_t, diff_f;
    dr_t          bor;
    logic [W-1:0] res_t, res_f;
    logic [W:0]   sub_t, sub_f;
    logic [W-1:0] add_t, add_f;
    logic [W-1:0] cor_t, cor_f;
    logic         accept, out_fire;

    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Sequencer with registered handshake outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state    <= PRE1;
                    in_ready <= 1'b0;
                end
                PRE1:     state <= EVAL_SUB;
                EVAL_SUB: state <= PRE2;
                PRE2:     state <= EVAL_COR;
                EVAL_COR: state <= DONE;
                DONE: if (out_fire) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end else begin
                    out_valid <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Single-rail operand capture at the accept handshake
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_a <= a;
            lat_b <= b;
        end
    end

    // Operand rails: 0/0 everywhere except during EVAL_SUB
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_at <= '0; op_af <= '0; op_bt <= '0; op_bf <= '0;
        end else if (state == PRE1) begin
            op_at <= lat_a; op_af <= ~lat_a;
            op_bt <= lat_b; op_bf <= ~lat_b;
        end else begin
            op_at <= '0; op_af <= '0; op_bt <= '0; op_bf <= '0;
        end
    end

    // a is extended with a 1 so the top difference bit is the no-borrow flag;
    // b's rails are swapped to form ~b, carry-in (1,0) adds the +1.
    (* keep_hierarchy = "yes" *)
    subtractor_13_bit_WDDL #(.N(W + 1)) u_sub (
        .a_t   ({1'b1, op_at}),
        .a_f   ({1'b0, op_af}),
        .b_t   ({1'b1, op_bf}),
        .b_f   ({1'b0, op_bt}),
        .cin_t (1'b1),
        .cin_f (1'b0),
        .s_t   (sub_t),
        .s_f   (sub_f)
    );

    // Difference and borrow rails: cleared in IDLE/PRE1, captured in EVAL_SUB, held after
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            diff_t <= '0;
            diff_f <= '0;
            bor    <= '0;
        end else if (state == EVAL_SUB) begin
            diff_t <= sub_t[W-1:0];
            diff_f <= sub_f[W-1:0];
            bor.t  <= sub_f[W];
            bor.f  <= sub_t[W];
        end else if (state == IDLE || state == PRE1) begin
            diff_t <= '0;
            diff_f <= '0;
            bor    <= '0;
        end
    end

    // Q-or-zero addend selected on the rails; zero bits still precharge via (t|f)
    assign add_t = Q_BITS & {W{bor.t}};
    assign add_f = (Q_BITS & {W{bor.f}}) | (~Q_BITS & {W{bor.t | bor.f}});

    (* keep_hierarchy = "yes" *)
    subtractor_13_bit_WDDL #(.N(W)) u_cor (
        .a_t   (diff_t),
        .a_f   (diff_f),
        .b_t   (add_t),
        .b_f   (add_f),
        .cin_t (1'b0),
        .cin_f (1'b1),
        .s_t   (cor_t),
        .s_f   (cor_f)
    );

    // Result rails: loaded from the correction adder, held in DONE, precharged otherwise
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            res_t <= '0;
            res_f <= '0;
        end else if (state == EVAL_COR) begin
            res_t <= cor_t;
            res_f <= cor_f;
        end else if (state != DONE || out_fire) begin
            res_t <= '0;
            res_f <= '0;
        end
    end

    assign res   = res_t;
    assign res_n = res_f;

`ifdef WDDL_RAIL_CHECK_EN
    logic viol;

    // Pairs must be complementary while evaluated/held and 0/0 while precharged
    always_comb begin
        viol = 1'b0;
        case (state)
            PRE1:     viol = |{op_at, op_af, op_bt, op_bf, diff_t, diff_f, bor.t, bor.f};
            EVAL_SUB: viol = ~&(op_at ^ op_af) | ~&(op_bt ^ op_bf);
            PRE2:     viol = |{res_t, res_f};
            EVAL_COR: viol = ~&(diff_t ^ diff_f) | ~(bor.t ^ bor.f);
            DONE:     viol = ~&(diff_t ^ diff_f) | ~(bor.t ^ bor.f) | ~&(res_t ^ res_f);
            default:  viol = 1'b0;
        endcase
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) rail_err <= 1'b0;
        else if (viol) rail_err <= 1'b1;
    end
`else
    assign rail_err = 1'b0;
`endif

endmodule

// File: tb/tb_wddl_mod_sub_seq.sv
// Scoreboard bench for wddl_mod_sub_seq: expected results are queued when
// operands are issued and compared when out_valid is observed.
module tb_wddl_mod_sub_seq;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] res, res_n;
    logic        rail_err;

    logic [11:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [11:0] fv;

    wddl_mod_sub_seq dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_n     (res_n),
        .rail_err  (rail_err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_mod_sub(input logic [11:0] x, input logic [11:0] y);
        int d;
        d = int'(x) - int'(y);
        if (d < 0) d += 3329;
        return 12'(d);
    endfunction

    // Issue one operation from IDLE; returns at the negedge after the accept edge
    task automatic send(input logic [11:0] x, input logic [11:0] y);
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        exp_q.push_back(ref_mod_sub(x, y));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid, sampled on negedges
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (res !== 12'h000 || res_n !== 12'h000) begin errors++; $display("FAIL reset_rails got=%h/%h want=000/000", res, res_n); end
        checks++; if (rail_err !== 1'b0) begin errors++; $display("FAIL reset_rail_err got=%b want=0", rail_err); end
        rst_b = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        logic [11:0] e;
        out_ready = 1'b1;
        send(12'd5, 12'd3);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_drop got=%b want=0", in_ready); end
        wait_valid(n);
        checks++; if (n != 5) begin errors++; $display("FAIL basic_latency got=%0d want=5", n); end
        e = exp_q.pop_front();
        checks++; if (res !== e) begin errors++; $display("FAIL basic_res got=%h want=%h", res, e); end
        checks++; if (res_n !== 12'hFFD) begin errors++; $display("FAIL basic_res_n got=%h want=ffd", res_n); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_6th got=%b want=0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_return got=ov%b/ir%b want=ov0/ir1", out_valid, in_ready); end
        checks++; if (res !== 12'h000 || res_n !== 12'h000) begin errors++; $display("FAIL basic_precharge got=%h/%h want=000/000", res, res_n); end
    endtask

    task automatic test_borrow();
        int n;
        logic [11:0] e;
        out_ready = 1'b1;
        send(12'd3, 12'd5);
        wait_valid(n);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL borrow_timeout got=%b want=1", out_valid); end
        e = exp_q.pop_front();
        checks++; if (res !== e || res !== 12'hCFF) begin errors++; $display("FAIL borrow_res got=%h want=%h", res, e); end
        checks++; if (res_n !== ~e) begin errors++; $display("FAIL borrow_res_n got=%h want=%h", res_n, ~e); end
        @(negedge clk);
    endtask

    task automatic test_boundaries();
        logic [11:0] ta [4] = '{12'd0,    12'd3328, 12'd3328, 12'd1234};
        logic [11:0] tb [4] = '{12'd3328, 12'd3328, 12'd0,    12'd2345};
        int n;
        logic [11:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb[i]);
            wait_valid(n);
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || res !== e) begin errors++; $display("FAIL bound_res[%0d] got=%h want=%h", i, res, e); end
            checks++; if (res_n !== ~e) begin errors++; $display("FAIL bound_res_n[%0d] got=%h want=%h", i, res_n, ~e); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [11:0] e;
        logic [11:0] hold;
        bit bad;
        out_ready = 1'b0;
        send(12'd100, 12'd200);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || res !== e) begin errors++; $display("FAIL bp_res got=%h want=%h", res, e); end
        hold = e;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            a = 12'd7; b = 12'd1;
            if (res !== hold || res_n !== ~hold || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL bp_stable got=%h/%h want=%h/%h", res, res_n, hold, ~hold); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (res !== 12'h000 || res_n !== 12'h000) begin errors++; $display("FAIL bp_precharge got=%h/%h want=000/000", res, res_n); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=ir%b/ov%b want=ir1/ov0", in_ready, out_valid); end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_no_latch got=ov1 want=ov0"); end
    endtask

    task automatic test_midreset();
        int n;
        logic [11:0] e;
        bit seen;
        out_ready = 1'b1;
        send(12'd9, 12'd4);
        @(negedge clk);
        rst_b = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 12'h000 || res_n !== 12'h000)
            begin errors++; $display("FAIL midreset_state got=ov%b ir%b %h/%h want=ov0 ir1 000/000", out_valid, in_ready, res, res_n); end
        @(negedge clk);
        rst_b = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midreset_discard got=ov1 want=ov0"); end
        send(12'd7, 12'd2);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || res !== e || res !== 12'd5) begin errors++; $display("FAIL midreset_after got=%h want=%h", res, e); end
        checks++; if (res_n !== ~e) begin errors++; $display("FAIL midreset_after_n got=%h want=%h", res_n, ~e); end
        @(negedge clk);
    endtask

`ifdef WDDL_RAIL_CHECK_EN
    task automatic test_rail_check();
        int n;
        logic [11:0] e;
        out_ready = 1'b1;
        send(12'd10, 12'd3);
        checks++; if (rail_err !== 1'b0) begin errors++; $display("FAIL rail_clean got=%b want=0", rail_err); end
        repeat (3) @(negedge clk);
        fv = ~dut.diff_t ^ 12'h001;
        force dut.diff_f = fv;
        @(negedge clk);
        checks++; if (rail_err !== 1'b1) begin errors++; $display("FAIL rail_set got=%b want=1", rail_err); end
        release dut.diff_f;
        wait_valid(n);
        void'(exp_q.pop_front());
        @(negedge clk);
        send(12'd20, 12'd5);
        wait_valid(n);
        e = exp_q.pop_front();
        checks++; if (res !== e) begin errors++; $display("FAIL rail_next_res got=%h want=%h", res, e); end
        checks++; if (rail_err !== 1'b1) begin errors++; $display("FAIL rail_sticky got=%b want=1", rail_err); end
        @(negedge clk);
    endtask
`else
    task automatic test_rail_check();
        checks++; if (rail_err !== 1'b0) begin errors++; $display("FAIL rail_tied got=%b want=0", rail_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_boundaries();
        test_backpressure();
        test_midreset();
        test_rail_check();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
